// File: rtl/rxecrc.sv
// rxecrc: receive-side Ethernet FCS check and strip.
// Folds every frame byte (FCS included) into a reflected CRC-32, holds the
// last four bytes in a delay line so the FCS never reaches the output, and
// flags CRC mismatches and runt frames at end of frame.
module rxecrc #(
    parameter int MIN_LEN = 64
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_ce,
    input  logic       i_en,
    input  logic       i_v,
    input  logic [7:0] i_d,
    output logic       o_v,
    output logic [7:0] o_d,
    output logic       o_err
);

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] MIN_LEN_U   = 32'(MIN_LEN);
    localparam logic [10:0] CNT_MAX     = 11'h7FF;
    localparam logic [2:0]  OCC_FULL    = 3'd4;

    // One byte of the reflected CRC-32, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    logic        armed_q, armed_d;
    logic        frame_q, frame_d;   // an armed frame has accepted at least one byte
    logic [31:0] crc_q,   crc_d;
    logic [10:0] cnt_q,   cnt_d;
    logic [2:0]  occ_q,   occ_d;
    logic [7:0]  dl_q [0:3];         // [0] holds the oldest byte once full
    logic [7:0]  dl_d [0:3];
    logic        ov_q,    ov_d;
    logic [7:0]  od_q,    od_d;
    logic        err_q,   err_d;

    // Next-state logic: everything holds unless the byte strobe is high.
    always_comb begin
        armed_d = armed_q;
        frame_d = frame_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        occ_d   = occ_q;
        dl_d    = dl_q;
        ov_d    = ov_q;
        od_d    = od_q;
        err_d   = err_q;
        if (i_ce) begin
            if (!i_v) begin
                // Gap cycle: arms the receiver; if a frame was running this is its end.
                armed_d = 1'b1;
                ov_d    = 1'b0;
                if (frame_q) begin
                    err_d = i_en && ((crc_q != CRC_RESIDUE) ||
                                     ({21'd0, cnt_q} < MIN_LEN_U));
                end
                frame_d = 1'b0;
                crc_d   = CRC_INIT;
                cnt_d   = 11'd0;
                occ_d   = 3'd0;
            end else if (armed_q) begin
                frame_d = 1'b1;
                err_d   = 1'b0;
                crc_d   = crc_byte(crc_q, i_d);
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 11'd1;
                end
                // Only once four bytes are buffered is the oldest known not to be FCS.
                ov_d = (occ_q == OCC_FULL);
                if (occ_q == OCC_FULL) begin
                    od_d = dl_q[0];
                end else begin
                    occ_d = occ_q + 3'd1;
                end
                dl_d[0] = dl_q[1];
                dl_d[1] = dl_q[2];
                dl_d[2] = dl_q[3];
                dl_d[3] = i_d;
            end else begin
                // Unarmed bytes (frame caught mid-way after reset) are dropped.
                ov_d = 1'b0;
            end
        end
    end

    // Control state and registered outputs, cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            armed_q <= 1'b0;
            frame_q <= 1'b0;
            crc_q   <= CRC_INIT;
            cnt_q   <= 11'd0;
            occ_q   <= 3'd0;
            ov_q    <= 1'b0;
            od_q    <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            armed_q <= armed_d;
            frame_q <= frame_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            occ_q   <= occ_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            err_q   <= err_d;
        end
    end

    // Delay-line storage; occupancy tracks which entries are meaningful.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++) begin
            dl_q[k] <= dl_d[k];
        end
    end

    assign o_v   = ov_q;
    assign o_d   = od_q;
    assign o_err = err_q;

endmodule

// File: tb/tb_rxecrc.sv
// tb_rxecrc: scoreboard bench for rxecrc, run on MIN_LEN=0 and MIN_LEN=64
// instances driven by the same byte stream.
module tb_rxecrc;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       e0;
        logic       e64;
    } exp_t;

    logic       clk;
    logic       i_reset_n, i_ce, i_en, i_v;
    logic [7:0] i_d;
    logic       o_v0, o_err0, o_v64, o_err64;
    logic [7:0] o_d0, o_d64;

    int tests;
    int fails;

    exp_t       sbq [$];
    logic [7:0] fbuf [0:127];

    // Expected-behaviour state
    logic       m_armed, m_inframe, m_v, m_err0, m_err64;
    logic [7:0] m_d;
    logic [7:0] m_dl [$];

    rxecrc #(.MIN_LEN(0)) dut0 (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_en(i_en),
        .i_v(i_v), .i_d(i_d), .o_v(o_v0), .o_d(o_d0), .o_err(o_err0)
    );

    rxecrc #(.MIN_LEN(64)) dut64 (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_en(i_en),
        .i_v(i_v), .i_d(i_d), .o_v(o_v64), .o_d(o_d64), .o_err(o_err64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock of stimulus; e0/e64 are the hand-derived error flags that
    // apply if this cycle ends a frame.
    task automatic step(input logic ce, input logic v, input logic [7:0] d,
                        input logic e0, input logic e64);
        exp_t x;
        @(negedge clk);
        i_ce = ce;
        i_v  = v;
        i_d  = d;
        if (ce) begin
            if (!v) begin
                if (m_inframe) begin
                    m_err0  = e0;
                    m_err64 = e64;
                end
                m_v       = 1'b0;
                m_armed   = 1'b1;
                m_inframe = 1'b0;
                m_dl.delete();
            end else if (m_armed) begin
                m_err0    = 1'b0;
                m_err64   = 1'b0;
                m_inframe = 1'b1;
                m_dl.push_back(d);
                if (m_dl.size() > 4) begin
                    m_d = m_dl.pop_front();
                    m_v = 1'b1;
                end else begin
                    m_v = 1'b0;
                end
            end else begin
                m_v = 1'b0;
            end
        end
        x.v   = m_v;
        x.d   = m_d;
        x.e0  = m_err0;
        x.e64 = m_err64;
        sbq.push_back(x);
    endtask

    // Frame of n bytes from fbuf; div>1 inserts div-1 strobe-low cycles
    // (with i_v dropped and junk data) before every accepted byte.
    task automatic send_frame(input int n, input logic en, input logic e0,
                              input logic e64, input int div);
        i_en = en;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < div - 1; j++) begin
                step(1'b0, 1'b0, 8'hA5, e0, e64);
            end
            step(1'b1, 1'b1, fbuf[i], e0, e64);
        end
        step(1'b1, 1'b0, 8'h00, e0, e64);
        step(1'b1, 1'b0, 8'h00, e0, e64);
    endtask

    task automatic load_check_frame(input logic [7:0] last);
        for (int i = 0; i < 9; i++) fbuf[i] = 8'h31 + 8'(i);
        fbuf[9]  = 8'h26;
        fbuf[10] = 8'h39;
        fbuf[11] = 8'hF4;
        fbuf[12] = last;
    endtask

    // Stimulus generator only: builds a payload and appends its FCS.
    task automatic load_payload(input int n);
        logic [31:0] c;
        for (int i = 0; i < n; i++) fbuf[i] = 8'(i * 7 + 3);
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ fbuf[i][b]) c = (c >> 1) ^ 32'hEDB8_8320;
                else                   c = c >> 1;
            end
        end
        c = ~c;
        fbuf[n]     = c[7:0];
        fbuf[n + 1] = c[15:8];
        fbuf[n + 2] = c[23:16];
        fbuf[n + 3] = c[31:24];
    endtask

    task automatic model_reset();
        m_armed   = 1'b0;
        m_inframe = 1'b0;
        m_v       = 1'b0;
        m_d       = 8'h00;
        m_err0    = 1'b0;
        m_err64   = 1'b0;
        m_dl.delete();
    endtask

    // Monitor: one scoreboard entry per stimulus clock.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                check("o_v min0", {31'd0, o_v0}, {31'd0, x.v});
                check("o_v min64", {31'd0, o_v64}, {31'd0, x.v});
                if (x.v) begin
                    check("o_d min0", {24'd0, o_d0}, {24'd0, x.d});
                    check("o_d min64", {24'd0, o_d64}, {24'd0, x.d});
                end
                check("o_err min0", {31'd0, o_err0}, {31'd0, x.e0});
                check("o_err min64", {31'd0, o_err64}, {31'd0, x.e64});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        i_reset_n = 1'b0;
        i_ce = 1'b0;
        i_en = 1'b1;
        i_v  = 1'b0;
        i_d  = 8'h00;
        model_reset();
        #1;
        check("reset o_v", {30'd0, o_v0, o_v64}, 32'd0);
        check("reset o_d", {16'd0, o_d0, o_d64}, 32'd0);
        check("reset o_err", {30'd0, o_err0, o_err64}, 32'd0);
        repeat (2) @(negedge clk);
        i_reset_n = 1'b1;

        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Good "123456789" frame: clean CRC, runt only for MIN_LEN=64.
        load_check_frame(8'hCB);
        send_frame(13, 1'b1, 1'b0, 1'b1, 1);
        // Corrupted last FCS byte.
        load_check_frame(8'hCA);
        send_frame(13, 1'b1, 1'b1, 1'b1, 1);
        // 64-byte frame exactly at the minimum, then a 63-byte one.
        load_payload(60);
        send_frame(64, 1'b1, 1'b0, 1'b0, 1);
        load_payload(59);
        send_frame(63, 1'b1, 1'b0, 1'b1, 1);
        // Check disabled: bad FCS and runt both ignored, data still forwarded.
        load_check_frame(8'hCA);
        send_frame(13, 1'b0, 1'b0, 1'b0, 1);
        // Byte strobe 1-in-3.
        load_check_frame(8'hCB);
        send_frame(13, 1'b1, 1'b0, 1'b1, 3);
        // Three-byte frame: no output, always an error with the check enabled.
        fbuf[0] = 8'h01; fbuf[1] = 8'h02; fbuf[2] = 8'h03;
        send_frame(3, 1'b1, 1'b1, 1'b1, 1);

        // Reset pulsed at byte 5 with i_v held high.
        load_check_frame(8'hCB);
        i_en = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, fbuf[i], 1'b0, 1'b0);
        @(negedge clk);
        i_reset_n = 1'b0;
        model_reset();
        #1;
        check("async reset o_v", {30'd0, o_v0, o_v64}, 32'd0);
        check("async reset o_err", {30'd0, o_err0, o_err64}, 32'd0);
        check("async reset o_d", {16'd0, o_d0, o_d64}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        i_ce = 1'b0;
        i_reset_n = 1'b1;
        for (int i = 5; i < 13; i++) step(1'b1, 1'b1, fbuf[i], 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        send_frame(13, 1'b1, 1'b0, 1'b1, 1);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rxecrc.md
# rxecrc

Receive-side Ethernet FCS stage: checks the CRC-32 of each incoming frame, strips the trailing 4-byte FCS, and forwards the remaining bytes to the IP header checksum stage. It sits between the preamble/SFD stripper and the IP header check, on the same byte stream and clock-enable. It also flags runt frames. Its error output is combined downstream with the IP-header error to discard the frame.

## Interface
- MIN_LEN, 64: minimum legal frame length in bytes, FCS included; 0 disables the runt check.
- i_clk  in  1  system clock; single clock domain.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_ce  in  1  byte strobe; state advances only on cycles with i_ce high.
- i_en  in  1  check enable; when low, o_err is never set, and data is still stripped and forwarded.
- i_v  in  1  frame valid; high for every byte of a frame, including the FCS.
- i_d  in  8  frame byte, destination MAC first, FCS last (FCS LSB byte first).
- o_v  out  1  output byte valid (frame minus FCS).
- o_d  out  8  output byte.
- o_err  out  1  frame error flag: CRC mismatch or runt.

## Operation
- Reset (async assert, sync deassert by the system) clears o_v, o_d=0, o_err, byte count, delay-line occupancy, and the armed flag. It sets crc=32'hFFFFFFFF.
- Armed flag:
  - Set on any i_ce cycle with i_v low.
  - Cleared by reset.
  - While not armed, i_v-high bytes are ignored: o_v=0, no CRC update, and o_err is not set.
  - A frame already in progress at reset release is therefore dropped silently.
- CRC:
  - IEEE 802.3, reflected polynomial 32'hEDB88320, init 32'hFFFFFFFF, one byte per i_ce cycle, LSB first, no final XOR inside the register.
  - Every byte, FCS included, is folded in.
  - A good frame leaves the residue 32'hDEBB20E3.
- Delay line: a 4-byte shift register plus a 3-bit occupancy count that saturates at 4.
  - On an armed i_ce cycle with i_v high, i_d shifts in.
  - If occupancy was already 4, the oldest byte goes to o_d with o_v=1; otherwise o_v=0.
- Byte counter: 11 bits, saturating at 2047, counts bytes of the current frame.
- End of frame: first i_ce cycle with i_v low after an armed frame.
  - o_v<=0 and the 4 buffered bytes (the FCS) are discarded.
  - o_err <= i_en && ((crc != 32'hDEBB20E3) || (count < MIN_LEN)).
  - crc, count, and occupancy are reinitialised.
- o_err is held until the next i_ce cycle with i_v high, where it clears to 0. It is never asserted while o_v is high.
- Frames of 1–4 bytes produce no o_v. They always raise o_err when i_en is high and MIN_LEN > 4.
- i_en is sampled only at end of frame. It is required stable during a frame.

## Timing
- All outputs are registered and change only on i_ce cycles; with i_ce low, every register holds.
- Latency: input byte n (0-based) appears on o_d in the i_ce cycle that accepts input byte n+4. The output stream is the input delayed by 4 accepted bytes.
- o_v for a frame of N bytes: high on exactly N−4 i_ce cycles; low from the end-of-frame cycle onward.
- o_err is valid from the end-of-frame i_ce cycle, coincident with the o_v falling edge, until the next frame's first byte.
- Back-to-back frames need at least one i_ce cycle of i_v low between them; that cycle is the end-of-frame cycle.
- Asserting reset mid-frame forces all outputs low immediately, independent of i_clk.

## Test plan
- MIN_LEN=0, i_en=1, frame "123456789" followed by 26 39 F4 CB → o_v high 9 cycles carrying 31..39, o_err=0 after end.
- Same frame with last byte CA → identical o_v/o_d stream, o_err=1 at end, cleared on the next frame's first byte.
- MIN_LEN=64, valid 60-byte payload plus correct FCS (64 bytes) → o_err=0. The same payload truncated to 59 bytes with its correct FCS (63 bytes) → o_err=1.
- i_en=0 with a corrupted FCS → o_err stays 0 and 9 bytes are still forwarded.
- i_ce toggling 1-in-3 during a valid frame → same o_d sequence as the i_ce=1 run, outputs frozen on i_ce-low cycles, o_err=0.
- Reset pulsed low at byte 5 of a frame while i_v stays high → o_v=0 immediately and no o_v for the rest of that frame. The next valid frame after an i_v-low gap is forwarded with o_err=0.
